// File: rtl/hamming_secded_decoder_pipe_if.sv
// rtl/hamming_secded_decoder_pipe_if.sv - codeword in / result out / counter status bundle for the SECDED decoder
interface hamming_secded_decoder_pipe_if #(
    parameter int DATA_W = 4,
    parameter int CHK_W  = 3,
    parameter int SECDED = 1,
    parameter int CNT_W  = 8
);
    localparam int CW_W = DATA_W + CHK_W + SECDED;

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              in_corr_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CHK_W-1:0]  out_syn;
    logic              out_sec;
    logic              out_ded;
    logic              cnt_clr;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ded_cnt;

    modport master (
        output in_valid, in_cw, in_corr_en, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, out_syn, out_sec, out_ded, sec_cnt, ded_cnt
    );

    modport slave (
        input  in_valid, in_cw, in_corr_en, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, out_syn, out_sec, out_ded, sec_cnt, ded_cnt
    );
endinterface

// File: rtl/hamming_secded_decoder_pipe.sv
// rtl/hamming_secded_decoder_pipe.sv - two-stage Hamming SEC/SECDED decoder with saturating error counters
module hamming_secded_decoder_pipe #(
    parameter int DATA_W = 4,
    parameter int CHK_W  = 3,
    parameter int SECDED = 1,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    hamming_secded_decoder_pipe_if.slave bus
);
    localparam int N    = DATA_W + CHK_W;
    localparam int CW_W = N + SECDED;

    // Hamming position (1-based) carrying data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 1;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
    logic [CHK_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s1_po_q, s1_po_d;
    logic              s1_corr_q, s1_corr_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CHK_W-1:0]  out_syn_q, out_syn_d;
    logic              out_sec_q, out_sec_d;
    logic              out_ded_q, out_ded_d;
    logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;

    logic              s2_load, s1_adv, in_ready_c, in_fire, out_fire;
    logic [CHK_W-1:0]  syn_c;
    logic              po_c;
    logic              syn_nz, syn_ok, flip_en, sec_c, ded_c;
    logic [CW_W-1:0]   cw_fix;
    logic [DATA_W-1:0] data_c;

    always_comb begin
        s2_load    = ~out_valid_q | bus.out_ready;
        s1_adv     = s1_valid_q & s2_load;
        in_ready_c = ~s1_valid_q | s1_adv;
        in_fire    = bus.in_valid & in_ready_c;
        out_fire   = out_valid_q & bus.out_ready;
    end

    always_comb begin
        syn_c = '0;
        for (int p = 1; p <= N; p++) begin
            for (int k = 0; k < CHK_W; k++) begin
                if (((p >> k) & 1) != 0) syn_c[k] = syn_c[k] ^ bus.in_cw[p-1];
            end
        end
        po_c = ^bus.in_cw;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        s1_po_d    = s1_po_q;
        s1_corr_d  = s1_corr_q;
        if (in_ready_c) s1_valid_d = bus.in_valid;
        if (in_fire) begin
            s1_cw_d   = bus.in_cw;
            s1_syn_d  = syn_c;
            s1_po_d   = po_c;
            s1_corr_d = bus.in_corr_en;
        end
    end

    // A syndrome pointing past the last Hamming position cannot be a single flip.
    always_comb begin
        syn_nz  = |s1_syn_q;
        syn_ok  = int'(s1_syn_q) <= N;
        flip_en = 1'b0;
        sec_c   = 1'b0;
        ded_c   = 1'b0;
        if (SECDED != 0) begin
            if (syn_nz && s1_po_q) begin
                if (syn_ok) begin
                    sec_c   = 1'b1;
                    flip_en = s1_corr_q;
                end else begin
                    ded_c = 1'b1;
                end
            end else if (!syn_nz && s1_po_q) begin
                sec_c = 1'b1;
            end else if (syn_nz && !s1_po_q) begin
                ded_c = 1'b1;
            end
        end else if (syn_nz) begin
            sec_c   = 1'b1;
            flip_en = s1_corr_q & syn_ok;
        end
        cw_fix = s1_cw_q;
        for (int p = 1; p <= N; p++) begin
            if (flip_en && int'(s1_syn_q) == p) cw_fix[p-1] = ~cw_fix[p-1];
        end
        data_c = '0;
        for (int j = 0; j < DATA_W; j++) begin
            data_c[j] = cw_fix[data_pos(j)-1];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_sec_d   = out_sec_q;
        out_ded_d   = out_ded_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = data_c;
                out_syn_d  = s1_syn_q;
                out_sec_d  = sec_c;
                out_ded_d  = ded_c;
            end
        end
    end

    // A clear in the same cycle as a counted transfer drops that event.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (bus.cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_fire) begin
            if (out_sec_q && !(&sec_cnt_q)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
            if (out_ded_q && !(&ded_cnt_q)) ded_cnt_d = ded_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_cw_q     <= '0;
            s1_syn_q    <= '0;
            s1_po_q     <= 1'b0;
            s1_corr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_syn_q   <= '0;
            out_sec_q   <= 1'b0;
            out_ded_q   <= 1'b0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cw_q     <= s1_cw_d;
            s1_syn_q    <= s1_syn_d;
            s1_po_q     <= s1_po_d;
            s1_corr_q   <= s1_corr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_sec_q   <= out_sec_d;
            out_ded_q   <= out_ded_d;
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_syn   = out_syn_q;
    assign bus.out_sec   = out_sec_q;
    assign bus.out_ded   = out_ded_q;
    assign bus.sec_cnt   = sec_cnt_q;
    assign bus.ded_cnt   = ded_cnt_q;
endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// tb/tb_hamming_secded_decoder_pipe.sv - scoreboard bench for the pipelined SECDED decoder (4/3/SECDED, 2-bit counters)
module tb_hamming_secded_decoder_pipe;
    logic clk;
    logic rst_n;

    hamming_secded_decoder_pipe_if #(.DATA_W(4), .CHK_W(3), .SECDED(1), .CNT_W(2)) bus ();

    hamming_secded_decoder_pipe #(.DATA_W(4), .CHK_W(3), .SECDED(1), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syn;
        logic       sec;
        logic       ded;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec;
    int   n_err;
    logic rand_bp;
    logic bp_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] cw, input logic corr);
        exp_t       e;
        logic [2:0] s;
        logic       po;
        logic [7:0] f;
        s = 3'd0;
        for (int p = 1; p <= 7; p++) if (cw[p-1]) s = s ^ 3'(p);
        po = ^cw;
        f  = cw;
        if (s != 0 && po && corr) f[s-1] = ~f[s-1];
        e.data = {f[6], f[5], f[4], f[2]};
        e.syn  = s;
        e.sec  = po;
        e.ded  = (s != 0) && !po;
        return e;
    endfunction

    task automatic send(input logic [7:0] cw, input logic corr, input exp_t e);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.in_cw      = cw;
        bus.in_corr_en = corr;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) sb.push_back(e);
        else chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else if (bus.out_ready) begin
                mon_e = sb.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(mon_e.data));
                chk("out_syn",  32'(bus.out_syn),  32'(mon_e.syn));
                chk("out_sec",  32'(bus.out_sec),  32'(mon_e.sec));
                chk("out_ded",  32'(bus.out_ded),  32'(mon_e.ded));
            end else begin
                chk("hold_data", 32'(bus.out_data), 32'(sb[0].data));
                chk("hold_syn",  32'(bus.out_syn),  32'(sb[0].syn));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog n_vec=%0d exp=finish", n_vec);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        logic [7:0] rcw;
        logic       rcorr;
        n_vec = 0;
        n_err = 0;
        rand_bp = 1'b0;
        bp_done = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_cw = '0;
        bus.in_corr_en = 1'b1;
        bus.out_ready = 1'b1;
        bus.cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_flags",     32'({bus.out_sec, bus.out_ded}), 32'd0);
        chk("rst_sec_cnt",   32'(bus.sec_cnt), 32'd0);
        chk("rst_ded_cnt",   32'(bus.ded_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors around the clean codeword 8'b01010101 (data 4'b1011).
        e = '{data: 4'b1011, syn: 3'd0, sec: 1'b0, ded: 1'b0}; send(8'b01010101, 1'b1, e);
        e = '{data: 4'b1011, syn: 3'd3, sec: 1'b1, ded: 1'b0}; send(8'b01010001, 1'b1, e);
        e = '{data: 4'b1010, syn: 3'd3, sec: 1'b1, ded: 1'b0}; send(8'b01010001, 1'b0, e);
        e = '{data: 4'b1011, syn: 3'd0, sec: 1'b1, ded: 1'b0}; send(8'b11010101, 1'b1, e);
        e = '{data: 4'b1011, syn: 3'd3, sec: 1'b0, ded: 1'b1}; send(8'b01010110, 1'b1, e);
        drain();
        chk("dir_sec_cnt", 32'(bus.sec_cnt), 32'd3);
        chk("dir_ded_cnt", 32'(bus.ded_cnt), 32'd1);

        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        chk("clr_sec_cnt", 32'(bus.sec_cnt), 32'd0);
        chk("clr_ded_cnt", 32'(bus.ded_cnt), 32'd0);

        e = '{data: 4'b1011, syn: 3'd3, sec: 1'b1, ded: 1'b0};
        send(8'b01010001, 1'b1, e);
        drain();
        chk("one_sec_cnt", 32'(bus.sec_cnt), 32'd1);
        for (int i = 0; i < 4; i++) send(8'b01010001, 1'b1, e);
        drain();
        chk("sat_sec_cnt", 32'(bus.sec_cnt), 32'd3);

        // Clear lands on the same edge as a counted single-error transfer.
        bus.out_ready = 1'b0;
        send(8'b01010001, 1'b1, e);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clr_race_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        chk("clr_race_cnt", 32'(bus.sec_cnt), 32'd0);
        @(posedge clk); #1;
        chk("clr_race_cnt2", 32'(bus.sec_cnt), 32'd0);

        // Five beats against a stalled output.
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    rcw = 8'($urandom_range(0, 255));
                    send(rcw, 1'b1, model(rcw, 1'b1));
                end
                bp_done = 1'b1;
            end
        join_none
        repeat (4) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_accepted", 32'(sb.size()), 32'd2);
        bus.out_ready = 1'b1;
        n = 0;
        while (!bp_done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_done", 32'(bp_done), 32'd1);
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rcw   = 8'($urandom_range(0, 255));
            rcorr = 1'($urandom_range(0, 1));
            send(rcw, rcorr, model(rcw, rcorr));
        end
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        e = '{data: 4'b1011, syn: 3'd3, sec: 1'b1, ded: 1'b0};
        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        send(8'b01010001, 1'b1, e);
        drain();
        chk("pre_rst_cnt", 32'(bus.sec_cnt), 32'd1);
        bus.out_ready = 1'b0;
        send(8'b01010001, 1'b1, e);
        send(8'b01010110, 1'b1, model(8'b01010110, 1'b1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_sec_cnt",   32'(bus.sec_cnt),   32'd0);
        chk("mid_rst_ded_cnt",   32'(bus.ded_cnt),   32'd0);
        sb.delete();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
